// File: rtl/ifb_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
package ifb_pkg;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD     = 32'h0;
    localparam int          IFB_DEPTH    = 8;
    localparam logic [31:0] IFB_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifb_queue.sv
// Circular instruction queue: one push, up to two pops per cycle, two
// combinational read ports at head and head+1.
module ifb_queue import ifb_pkg::*; #(
    parameter int  DEPTH = IFB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          hz1_clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic [1:0]    pop_cnt,
    input  logic          flush,
    output logic [31:0]   rd0,
    output logic [31:0]   rd1,
    output logic [CW-1:0] count
);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nx;

    assign head_nx = head + 1'b1;

    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_cnt);
            if (push)
                tail <= tail + 1'b1;
            count <= count + CW'(push) - CW'(pop_cnt);
        end
    end

    // Storage is not reset: contents are invisible while count is zero.
    always_ff @(posedge hz1_clk) begin
        if (push && !flush)
            mem[tail] <= push_data;
    end

    assign rd0 = (count >= CW'(1)) ? mem[head]    : NOP_WORD;
    assign rd1 = (count >= CW'(2)) ? mem[head_nx] : NOP_WORD;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: single-outstanding fetch FSM, pc and redirect
// handling in front of ifb_queue. Define IFB_STATS_EN for fetch/stall counters.
module instr_fetch_buffer import ifb_pkg::*; #(
    parameter int          DEPTH    = IFB_DEPTH,
    parameter logic [31:0] RESET_PC = IFB_RESET_PC
) (
    input  logic        hz1_clk,
    input  logic        n_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        freeze1,
    input  logic        freeze2,
    input  logic        dependency_on_ins2,
    output logic [31:0] instruction0,
    output logic [31:0] instruction1,
    output logic        nothing_filled
`ifdef IFB_STATS_EN
    ,
    output logic [15:0] fetched_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   pc;
    logic [31:0]   req_addr;
    logic          discard;
    logic [CW-1:0] count;
    logic [CW-1:0] level;
    logic          pop0;
    logic          pop1;
    logic [1:0]    pop_cnt;
    logic          push;

    // Pops are suppressed on a redirect cycle since the queue is flushed anyway.
    assign pop0    = !freeze1 && (count != '0) && !redirect_valid;
    assign pop1    = pop0 && !freeze2 && !dependency_on_ins2 && (count >= CW'(2));
    assign pop_cnt = {1'b0, pop0} + {1'b0, pop1};
    assign push    = (state == FETCH_REQ) && imem_ack && !discard && !redirect_valid;
    assign level   = count - CW'(pop_cnt);

    assign imem_req       = (state == FETCH_REQ);
    assign imem_addr      = imem_req ? req_addr : pc;
    assign nothing_filled = (count == '0);

    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
        end else if (state == FETCH_IDLE) begin
            // A redirect in IDLE delays issue by one cycle so req_addr sees the new pc.
            if (redirect_valid)
                pc <= redirect_pc;
            else if (level < CW'(DEPTH)) begin
                state    <= FETCH_REQ;
                req_addr <= pc;
            end
        end else begin
            if (redirect_valid) begin
                pc      <= redirect_pc;
                discard <= !imem_ack;
            end else if (imem_ack) begin
                discard <= 1'b0;
                if (!discard)
                    pc <= pc + 32'd4;
            end
            if (imem_ack)
                state <= FETCH_IDLE;
        end
    end

    ifb_queue #(.DEPTH(DEPTH)) u_queue (
        .hz1_clk   (hz1_clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data (imem_rdata),
        .pop_cnt   (pop_cnt),
        .flush     (redirect_valid),
        .rd0       (instruction0),
        .rd1       (instruction1),
        .count     (count)
    );

`ifdef IFB_STATS_EN
    always_ff @(posedge hz1_clk or negedge n_rst) begin
        if (!n_rst) begin
            fetched_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (push && fetched_cnt != 16'hFFFF)
                fetched_cnt <= fetched_cnt + 16'd1;
            if (freeze1 && count != '0 && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue depth in words (power of 2, >=4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port hz1_clk, input, 1, clock, all state on rising edge.
REQ-004 SHALL have port n_rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1, read data valid this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-009 SHALL have port redirect_valid, input, 1, flush the queue and restart fetch.
REQ-010 SHALL have port redirect_pc, input, 32, new fetch address.
REQ-011 SHALL have port freeze1, input, 1, slot 0 not consumed this cycle.
REQ-012 SHALL have port freeze2, input, 1, slot 1 not consumed this cycle.
REQ-013 SHALL have port dependency_on_ins2, input, 1, slot 1 held because it depends on slot 0.
REQ-014 SHALL have port instruction0, output, 32, queue head, 32'h0 when empty.
REQ-015 SHALL have port instruction1, output, 32, head+1, 32'h0 when count<2.
REQ-016 SHALL have port nothing_filled, output, 1, high when count==0.

Function
REQ-017 SHALL hold a circular queue of DEPTH words with head/tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-018 SHALL drive instruction0/instruction1 combinationally from queue storage, with zero-cycle latency from head movement.
REQ-019 SHALL pop slot 0 when !freeze1 && count>=1.
REQ-020 SHALL pop slot 1 only when slot 0 pops && !freeze2 && !dependency_on_ins2 && count>=2.
REQ-021 SHALL, after a 1-pop cycle, present the old instruction1 as instruction0 on the next cycle.
REQ-022 SHALL run fetch FSM IDLE -> REQ -> IDLE: IDLE->REQ when (count - pops + outstanding) < DEPTH; REQ->IDLE on imem_ack.
REQ-023 SHALL allow at most one outstanding request and hold imem_req=1 and imem_addr stable in REQ until imem_ack.
REQ-024 SHALL, on imem_ack, write imem_rdata at tail and advance pc by 4, with 32-bit wrap at 32'hFFFF_FFFC.
REQ-025 SHALL, on a simultaneous push and pop, update count by push minus pops in one cycle, including when full with a pop.
REQ-026 SHALL, on redirect_valid, next cycle set count=0, head=tail, pc=redirect_pc, and ignore pops that cycle.
REQ-027 SHALL, on redirect_valid during REQ, discard the returning ack data (not enqueue, pc unchanged) and then request redirect_pc.
REQ-028 SHALL let redirect win over a same-cycle imem_ack in REQ-027.
REQ-029 SHALL never issue a request when the queue would overflow, and SHALL never pop past empty.

Reset
REQ-030 SHALL, on n_rst low, immediately set FSM=IDLE, imem_req=0, imem_addr=pc=RESET_PC, count=0, pointers=0, discard flag=0, and outputs instruction0=instruction1=0, nothing_filled=1.
REQ-031 SHALL not clear queue storage on reset, since it is unobservable while count==0.
REQ-032 SHALL drop an outstanding request when reset is asserted mid-transaction.

Configuration
REQ-033 SHALL, with IFB_STATS_EN defined, add outputs fetched_cnt[15:0] (saturating count of enqueued words) and stall_cnt[15:0] (saturating count of cycles with freeze1 && count>0), both reset to 0.
REQ-034 SHALL omit those ports and counters when IFB_STATS_EN is undefined, with all other behaviour identical.

Structure
REQ-035 SHALL place in shared package ifb_pkg: fetch FSM state enum, NOP_WORD=32'h0, default DEPTH, default RESET_PC.
REQ-036 SHALL isolate storage and pointers in sub-module ifb_queue (push, pop count 0..2, two read ports); FSM, pc and redirect stay in instr_fetch_buffer.

Verification
REQ-037 SHALL cover reset then single-cycle ack with freeze1=1: words 0x00100093,0x00200113,... at addr 0,4,...; queue full after 8 acks, imem_req stays 0.
REQ-038 SHALL cover full queue with freeze1=freeze2=0: two pops per cycle, instruction0/1 advance by two words, fetch resumes next cycle.
REQ-039 SHALL cover dependency_on_ins2=1 for one cycle: one pop; next instruction0 equals previous instruction1.
REQ-040 SHALL cover redirect_valid with redirect_pc=0x40 while a request waits 3 cycles: stale ack discarded, nothing_filled=1, next imem_addr=0x40.
REQ-041 SHALL cover RESET_PC=32'hFFFF_FFF8 with two acks: addresses FFFF_FFF8, FFFF_FFFC, then 0.
REQ-042 SHALL cover n_rst asserted while imem_req=1: imem_req=0 and count=0 at once, and fetch restarts at RESET_PC after release.
